// File: rtl/tlv_i2c_responder_pkg.sv
// Shared types and constants for the TLV magnetic-sensor I2C responder.
package tlv_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    WAIT_STOP
  } state_t;

  localparam int unsigned FRAME_LEN    = 7;
  localparam logic [7:0]  PAD_BYTE     = 8'hFF;
  localparam logic [6:0]  DEFAULT_ADDR = 7'h35;

  localparam logic [2:0] IDX_X_HI  = 3'd0;
  localparam logic [2:0] IDX_Y_HI  = 3'd1;
  localparam logic [2:0] IDX_Z_HI  = 3'd2;
  localparam logic [2:0] IDX_T_HI  = 3'd3;
  localparam logic [2:0] IDX_XY_LO = 3'd4;
  localparam logic [2:0] IDX_Z_LO  = 3'd5;
  localparam logic [2:0] IDX_T_LO  = 3'd6;

  function automatic logic [7:0] frame_byte(input logic [11:0] x, y, z, t,
                                            input logic [1:0] cnt,
                                            input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      IDX_X_HI:  b = x[11:4];
      IDX_Y_HI:  b = y[11:4];
      IDX_Z_HI:  b = z[11:4];
      IDX_T_HI:  b = {t[11:8], cnt, 2'b00};
      IDX_XY_LO: b = {x[3:0], y[3:0]};
      IDX_Z_LO:  b = {4'b0001, z[3:0]};
      IDX_T_LO:  b = t[7:0];
      default:   b = PAD_BYTE;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tlv_i2c_responder_line_filter.sv
// Two-flop synchronizer plus stability filter for one open-drain bus line.
module i2c_line_filter #(
  parameter int unsigned FILTER_DEPTH = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [1:0] sync;
  logic [3:0] cnt;

  // rise/fall are registered alongside level, so they mark the cycle level changes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync  <= '1;
      level <= 1'b1;
      cnt   <= '0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line_in};
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == 4'(FILTER_DEPTH - 1)) begin
        level <= sync[1];
        rise  <= sync[1];
        fall  <= ~sync[1];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: rtl/tlv_i2c_responder.sv
// I2C target emulating a 3D magnetic sensor: 7-byte frame reads, config-byte writes.
module tlv_i2c_responder
  import tlv_i2c_pkg::*;
#(
  parameter logic [6:0]  I2C_ADDRESS    = DEFAULT_ADDR,
  parameter int unsigned FILTER_DEPTH   = 3,
  parameter int unsigned NUM_WRITE_REGS = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  input  logic [11:0]                 mag_x,
  input  logic [11:0]                 mag_y,
  input  logic [11:0]                 mag_z,
  input  logic [11:0]                 temperature,
  output logic [8*NUM_WRITE_REGS-1:0] wr_regs,
  output logic                        wr_strobe,
  output logic                        read_done,
  output logic                        busy
);

  localparam int unsigned WPTR_W = $clog2(NUM_WRITE_REGS + 1);

  logic scl_f, scl_rise, scl_fall, sda_f, sda_rise, sda_fall;
  logic fall_d, start_c, stop_c, addr_hit, rw, ack_rise, wr_any, rd_any;
  logic [6:0] shift;
  logic [7:0] byte_in, cur_byte;
  logic [3:0] bit_cnt;
  logic [2:0] rptr;
  logic [WPTR_W-1:0] wptr;
  logic [1:0] frame_cnt, snap_cnt;
  logic [11:0] snap_x, snap_y, snap_z, snap_t;
  state_t state, state_next;

  i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl (
    .clk(clk), .reset_n(reset_n), .line_in(scl_in),
    .level(scl_f), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_filter #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda (
    .clk(clk), .reset_n(reset_n), .line_in(sda_in),
    .level(sda_f), .rise(sda_rise), .fall(sda_fall)
  );

  assign start_c  = sda_fall & scl_f;
  assign stop_c   = sda_rise & scl_f;
  assign byte_in  = {shift, sda_f};
  assign addr_hit = (shift == I2C_ADDRESS);
  assign cur_byte = frame_byte(snap_x, snap_y, snap_z, snap_t, snap_cnt, rptr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // fall-driven actions use fall_d so SDA moves one cycle after the SCL fall is seen
  always_comb begin
    state_next = state;
    if (stop_c) begin
      state_next = IDLE;
    end else if (start_c) begin
      state_next = ADDR;
    end else begin
      case (state)
        ADDR:     if (scl_rise && bit_cnt == 4'd7) state_next = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK: if (fall_d && ack_rise) state_next = rw ? RD_BYTE : WR_BYTE;
        WR_BYTE:  if (scl_rise && bit_cnt == 4'd7) state_next = WR_ACK;
        WR_ACK:   if (fall_d && ack_rise) state_next = WR_BYTE;
        RD_BYTE:  if (fall_d && bit_cnt == 4'd8) state_next = RD_ACK;
        RD_ACK:   if (scl_rise) state_next = sda_f ? WAIT_STOP : RD_BYTE;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fall_d    <= 1'b0;
      sda_oe    <= 1'b0;
      wr_regs   <= '0;
      wr_strobe <= 1'b0;
      read_done <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      snap_cnt  <= '0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_z    <= '0;
      snap_t    <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
      rptr      <= '0;
      wptr      <= '0;
      rw        <= 1'b0;
      ack_rise  <= 1'b0;
      wr_any    <= 1'b0;
      rd_any    <= 1'b0;
    end else begin
      fall_d    <= scl_fall;
      wr_strobe <= 1'b0;
      read_done <= 1'b0;
      if (stop_c || start_c) begin
        wr_strobe <= wr_any;
        read_done <= rd_any;
        if (rd_any) frame_cnt <= frame_cnt + 2'd1;
        wr_any   <= 1'b0;
        rd_any   <= 1'b0;
        sda_oe   <= 1'b0;
        bit_cnt  <= '0;
        ack_rise <= 1'b0;
        wptr     <= '0;
        rptr     <= '0;
        if (stop_c) busy <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              ack_rise <= 1'b0;
              busy     <= addr_hit;
              if (addr_hit) begin
                rw       <= sda_f;
                snap_x   <= mag_x;
                snap_y   <= mag_y;
                snap_z   <= mag_z;
                snap_t   <= temperature;
                snap_cnt <= frame_cnt;
              end
            end
          end
          ADDR_ACK, WR_ACK: begin
            if (scl_rise) ack_rise <= 1'b1;
            if (fall_d) begin
              if (!ack_rise) begin
                sda_oe <= 1'b1;
              end else begin
                ack_rise <= 1'b0;
                bit_cnt  <= '0;
                sda_oe   <= (state == ADDR_ACK && rw) ? ~cur_byte[7] : 1'b0;
              end
            end
          end
          WR_BYTE: if (scl_rise) begin
            shift   <= byte_in[6:0];
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt  <= '0;
              ack_rise <= 1'b0;
              wr_any   <= 1'b1;
              for (int unsigned k = 0; k < NUM_WRITE_REGS; k++)
                if (wptr == WPTR_W'(k)) wr_regs[8*k +: 8] <= byte_in;
              if (wptr != WPTR_W'(NUM_WRITE_REGS)) wptr <= wptr + WPTR_W'(1);
            end
          end
          RD_BYTE: begin
            if (scl_rise) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) rd_any <= 1'b1;
            end
            if (fall_d) begin
              if (bit_cnt == 4'd8) sda_oe <= 1'b0;
              else                 sda_oe <= ~cur_byte[3'd7 - bit_cnt[2:0]];
            end
          end
          RD_ACK: if (scl_rise) begin
            bit_cnt <= '0;
            if (!sda_f && rptr != 3'(FRAME_LEN)) rptr <= rptr + 3'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/tlv_i2c_responder.md
Name: tlv_i2c_responder

Overview:
- I2C target (responder) that emulates one 3D-magnetic sensor at 7-bit address 0x35 on a shared SCL/SDA pair.
- Answers the ball-joint readout master: a 7-byte sensor frame on reads, up to NUM_WRITE_REGS config bytes on writes.
- Used for hardware-in-the-loop and bench emulation of the sensor.
- Field values come in from fabric ports; the frame snapshot is taken at address match.

Parameters:
- I2C_ADDRESS, 7'h35, target address matched in the address byte.
- FILTER_DEPTH, 3, clk cycles a synchronized SCL/SDA level must be stable before it is accepted (range 1..15).
- NUM_WRITE_REGS, 4, number of write-capture byte registers.

Ports:
- clk  in  1  system clock, ≥ 20× SCL rate.
- reset_n  in  1  asynchronous, active-low reset.
- scl_in  in  1  bus SCL level (async).
- sda_in  in  1  bus SDA level (async).
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- mag_x, mag_y, mag_z  in  12 each  field values.
- temperature  in  12  temperature value.
- wr_regs  out  8*NUM_WRITE_REGS  captured write bytes; byte k sits at [8k+7:8k].
- wr_strobe  out  1  one-cycle pulse at STOP ending a write with ≥1 data byte.
- read_done  out  1  one-cycle pulse at STOP/Sr ending a read of ≥1 byte.
- busy  out  1  high from address match to STOP.

Behaviour:
- Reset values: sda_oe=0, wr_regs=0, wr_strobe=0, read_done=0, busy=0, frame_cnt=0, state=IDLE. Reset mid-transfer releases SDA immediately.
- Input path:
  - 2-FF synchronizer, then FILTER_DEPTH stability filter, giving scl_f/sda_f.
  - Edge detects are registered, so events lag the bus by 2+FILTER_DEPTH cycles.
- Bus conditions:
  - START/Sr: sda_f falls while scl_f is high. Enter ADDR from any state; bit counter cleared; sda_oe=0.
  - STOP: sda_f rises while scl_f is high. Go to IDLE, busy=0, sda_oe=0, strobes as specified.
- Data timing:
  - Data is sampled on the scl_f rising edge.
  - sda_oe changes only on the scl_f falling edge, one cycle after the edge is detected.
  - No clock stretching.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - On the 8th rise: if addr==I2C_ADDRESS, go to ADDR_ACK; otherwise go to IDLE, never drive, ignore until next START.
    - On match: busy=1 and the frame snapshot is latched.
  - ADDR_ACK: drive sda_oe=1 for the ack clock. Release on the following fall, then:
    - rw=0: go to WR_BYTE.
    - rw=1: go to RD_BYTE, with the MSB of byte 0 driven on that same fall.
  - WR_BYTE: shift 8 bits.
    - On the 8th rise: store to wr_regs[wptr] if wptr<NUM_WRITE_REGS, then wptr++.
    - Extra bytes are still acked and discarded. Go to WR_ACK.
  - WR_ACK: ack as in ADDR_ACK, then back to WR_BYTE.
  - RD_BYTE: drive the bits of frame[rptr] (sda_oe = ~bit). Release after the 8th bit, go to RD_ACK.
  - RD_ACK: sample the master's bit on the rise.
    - ACK (0): rptr++, go to RD_BYTE.
    - NACK (1): go to WAIT_STOP, SDA released until STOP/Sr.
- Frame bytes (snapshot at match):
  - B0 = x[11:4]
  - B1 = y[11:4]
  - B2 = z[11:4]
  - B3 = {t[11:8], frame_cnt[1:0], 2'b00}
  - B4 = {x[3:0], y[3:0]}
  - B5 = {4'b0001, z[3:0]}
  - B6 = t[7:0]
  - rptr ≥ 7 returns 8'hFF.
- frame_cnt (2 bits) increments, wrapping 3→0, with each read_done.
- wptr and rptr reset to 0 on every START/Sr.
- A write wr_strobe also fires on Sr.
- START and STOP both detected in one cycle is impossible after filtering; if seen, STOP takes precedence.

Decomposition:
- Shared package (tlv_i2c_pkg):
  - state enum.
  - frame length constant (7).
  - byte-index constants.
  - PAD_BYTE 8'hFF.
  - default address 7'h35.
- Sub-module i2c_line_filter: synchronizer plus stability filter, instantiated once per line. It outputs the filtered level and rise/fall pulses.

Test Plan:
1. Reset_n low mid-read (sda_oe=1) -> sda_oe=0 asynchronously; all outputs at reset values; no strobe after release.
2. Write addr 0x35, bytes 0x11, 0x10, STOP -> both bytes acked; wr_regs[15:0]=16'h1011; wr_strobe pulses once.
3. Read 7 bytes (ack 6, NACK last) with x=12'hABC, y=12'h123, z=12'h456, t=12'h789, frame_cnt=0 -> bytes AB 12 45 70 C3 16 89; read_done pulses; frame_cnt becomes 1.
4. Address 0x70 write -> no ack (SDA high on the 9th clock); busy stays 0; wr_regs unchanged.
5. Read 9 bytes -> bytes 7 and 8 = 0xFF; four consecutive reads -> B3[3:2] sequence 0,1,2,3, then wraps to 0.
6. Write byte 0x55, then Sr and read 1 byte with NACK -> wr_strobe at Sr; wr_regs[7:0]=0x55; read returns B0; read_done at STOP; a 1-cycle SDA glitch during SCL high produces no false START/STOP.
